code_lock_fsm: RTL and testbench
================================

# code_lock_fsm

Four-digit keypad code lock that consumes 4-bit key digits and checks each one against a stored code nibble with a 4-bit equality compare. The compare is the team's `equal_comparator_four`, one instance per accepted digit. The block sits directly downstream of that comparator and turns per-digit equal/not-equal results into lock decisions. It drives the unlock and alarm outputs, counts consecutive failures, enforces a lockout, and lets the user change the code while the lock is open.

## Interface
- DEFAULT_CODE, 16'h1234: code loaded at reset; digit 0 is bits [15:12], digit 3 is bits [3:0].
- OPEN_CYCLES, 8: number of cycles unlock stays high after a correct entry.
- MAX_FAILS, 3: consecutive wrong entries that trigger lockout; range 1..7.
- LOCK_CYCLES, 16: lockout duration in cycles.
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_valid  input  1  one-cycle strobe: key_in holds a digit.
- key_in  input  4  digit value, sampled when key_valid=1.
- clear  input  1  abort the current entry or relock.
- set_req  input  1  request a code change; honoured only in OPEN.
- unlock  output  1  high while in OPEN.
- alarm  output  1  high while in LOCKOUT.
- err  output  1  one-cycle pulse on a wrong 4-digit entry.
- code_set  output  1  one-cycle pulse when a new code is committed.
- digit_cnt  output  2  number of digits accepted in the current entry or set sequence.
- fail_cnt  output  3  consecutive failure count.

## Operation
- Reset (async, rst_n=0):
  - state=IDLE, code=DEFAULT_CODE.
  - All counters are 0.
  - unlock, alarm, err, code_set, digit_cnt and fail_cnt are all 0.
- All outputs are registered.
- States are IDLE, ENTRY, OPEN, SET and LOCKOUT.
- IDLE:
  - key_valid accepts digit 0, goes to ENTRY, digit_cnt=1.
  - A sticky mismatch flag is set if key_in differs from code[15:12].
- ENTRY:
  - Each key_valid accepts digit i (i = digit_cnt) and compares it to the matching code nibble.
  - A mismatch sets the sticky mismatch flag.
  - On the 4th digit:
    - All four digits equal: go to OPEN, fail_cnt=0.
    - Otherwise, err pulses and fail_cnt increments.
      - If the new fail_cnt equals MAX_FAILS, go to LOCKOUT.
      - Otherwise, go to IDLE.
  - digit_cnt returns to 0 in both cases.
- OPEN:
  - unlock=1 and a timer counts OPEN_CYCLES cycles, then the block returns to IDLE.
  - clear returns to IDLE immediately.
  - set_req goes to SET with digit_cnt=0 and unlock=0.
  - key_valid is ignored.
- SET:
  - Each key_valid writes key_in into a shadow code register, digit 0 first.
  - On the 4th digit the shadow register is copied to code, code_set pulses, and the block goes to IDLE.
  - clear aborts: the old code is kept and the block goes to IDLE.
  - The SET state has no timeout.
- LOCKOUT:
  - alarm=1 for LOCK_CYCLES cycles.
  - key_valid, clear and set_req are all ignored.
  - On exit fail_cnt=0 and state=IDLE.
- clear in IDLE or ENTRY discards any partial entry, returns to IDLE and does not change fail_cnt.
- Priority within a cycle is clear > set_req > key_valid.
- set_req outside OPEN is ignored.

## Timing
- A digit sampled at edge N is reflected in digit_cnt after edge N.
- When the 4th correct digit is sampled at edge N:
  - unlock is high from after edge N for exactly OPEN_CYCLES cycles.
  - unlock is low after edge N+OPEN_CYCLES.
- A wrong 4th digit at edge N makes err high for the single cycle after edge N.
- alarm rises together with the err pulse of the MAX_FAILS-th failure and stays high for exactly LOCK_CYCLES cycles.
- code_set pulses in the cycle after the 4th SET digit is sampled.
- A new code takes effect for the next entry, with no dead cycle.
- Back-to-back key_valid on consecutive cycles must be accepted.
- Asserting rst_n mid-operation restores DEFAULT_CODE, discarding any code set since.
- Timer counters must be wide enough for their parameter (clog2 sizing) and must not wrap.

## Test plan
- Correct entry: after reset, enter 1,2,3,4 on consecutive cycles. Required:
  - unlock=1 for 8 cycles.
  - err never pulses.
  - fail_cnt=0.
  - Afterwards the block is back in IDLE with digit_cnt=0.
- Wrong entries: enter 1,2,3,5 twice. Required:
  - err pulses twice and fail_cnt=2.
  - Then entering 1,2,3,4 gives unlock=1 and fail_cnt=0.
- Lockout: enter three wrong codes. Required:
  - alarm=1 for 16 cycles.
  - Entering 1,2,3,4 during lockout is ignored (unlock stays 0).
  - After lockout, fail_cnt=0 and 1,2,3,4 unlocks.
- Clear:
  - Enter 1,2, assert clear, then enter 1,2,3,4. Required: unlock with fail_cnt unchanged.
  - clear during OPEN drops unlock on the next edge.
  - Assert clear and key_valid in the same cycle. Required: clear wins and digit_cnt=0.
- Code change:
  - In OPEN, pulse set_req and enter A,B,C,D. Required: code_set pulses.
  - Then 1,2,3,4 gives err; A,B,C,D gives unlock.
  - Abort a SET after 2 digits with clear. Required: the old code still works.
- Async reset: assert rst_n=0 mid-entry, mid-OPEN and mid-LOCKOUT (after changing the code). Required:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After reset, 1,2,3,4 unlocks.

Source files
------------

// File: rtl/code_lock_fsm.sv
// Four-digit keypad code lock: per-digit equality compares feed an FSM that
// drives unlock/alarm, counts consecutive failures and allows code changes while open.

module equal_comparator_four (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       eq
);
   assign eq = (a == b);
endmodule

module code_lock_fsm #(
   parameter logic [15:0] DEFAULT_CODE = 16'h1234,
   parameter int          OPEN_CYCLES  = 8,
   parameter int          MAX_FAILS    = 3,
   parameter int          LOCK_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_in,
   input  logic       clear,
   input  logic       set_req,
   output logic       unlock,
   output logic       alarm,
   output logic       err,
   output logic       code_set,
   output logic [1:0] digit_cnt,
   output logic [2:0] fail_cnt
);
   localparam int OW = $clog2(OPEN_CYCLES + 1);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_OPEN, S_SET, S_LOCK} state_t;

   state_t           state, st_nx;
   logic [3:0][3:0]  code, code_nx;      // code[3] is digit 0
   logic [3:0][3:0]  shadow, shadow_nx;
   logic [1:0]       cnt_nx;
   logic [2:0]       fail_nx, fail_inc;
   logic             mis, mis_nx;
   logic [OW-1:0]    otmr, otmr_nx;
   logic [LW-1:0]    ltmr, ltmr_nx;
   logic             err_nx, set_nx;
   logic [3:0]       dig_eq;
   logic             key_eq;

   // One comparator per digit position; the active one is picked by digit_cnt
   for (genvar i = 0; i < 4; i++) begin : g_cmp
      equal_comparator_four u_cmp (.a(key_in), .b(code[3-i]), .eq(dig_eq[i]));
   end

   assign key_eq   = dig_eq[digit_cnt];
   assign fail_inc = fail_cnt + 3'd1;

   always_comb begin
      st_nx     = state;
      code_nx   = code;
      shadow_nx = shadow;
      cnt_nx    = digit_cnt;
      fail_nx   = fail_cnt;
      mis_nx    = mis;
      otmr_nx   = otmr;
      ltmr_nx   = ltmr;
      err_nx    = 1'b0;
      set_nx    = 1'b0;
      case (state)
         S_IDLE: begin
            if (clear) begin
               cnt_nx = 2'd0;
               mis_nx = 1'b0;
            end else if (key_valid) begin
               st_nx  = S_ENTRY;
               cnt_nx = 2'd1;
               mis_nx = ~key_eq;
            end
         end
         S_ENTRY: begin
            if (clear) begin
               st_nx  = S_IDLE;
               cnt_nx = 2'd0;
               mis_nx = 1'b0;
            end else if (key_valid) begin
               if (digit_cnt == 2'd3) begin
                  cnt_nx = 2'd0;
                  mis_nx = 1'b0;
                  if (!mis && key_eq) begin
                     st_nx   = S_OPEN;
                     fail_nx = 3'd0;
                     otmr_nx = '0;
                  end else begin
                     err_nx  = 1'b1;
                     fail_nx = fail_inc;
                     ltmr_nx = '0;
                     st_nx   = (fail_inc == 3'(MAX_FAILS)) ? S_LOCK : S_IDLE;
                  end
               end else begin
                  cnt_nx = digit_cnt + 2'd1;
                  mis_nx = mis | ~key_eq;
               end
            end
         end
         S_OPEN: begin
            if (clear) begin
               st_nx = S_IDLE;
            end else if (set_req) begin
               st_nx  = S_SET;
               cnt_nx = 2'd0;
            end else if (otmr == OW'(OPEN_CYCLES - 1)) begin
               st_nx = S_IDLE;
            end else begin
               otmr_nx = otmr + 1'b1;
            end
         end
         S_SET: begin
            if (clear) begin
               st_nx  = S_IDLE;
               cnt_nx = 2'd0;
            end else if (key_valid) begin
               shadow_nx[2'd3 - digit_cnt] = key_in;
               if (digit_cnt == 2'd3) begin
                  // bypass the shadow for the last nibble so the commit needs no extra cycle
                  code_nx = {shadow[3], shadow[2], shadow[1], key_in};
                  set_nx  = 1'b1;
                  st_nx   = S_IDLE;
                  cnt_nx  = 2'd0;
               end else begin
                  cnt_nx = digit_cnt + 2'd1;
               end
            end
         end
         S_LOCK: begin
            if (ltmr == LW'(LOCK_CYCLES - 1)) begin
               st_nx   = S_IDLE;
               fail_nx = 3'd0;
            end else begin
               ltmr_nx = ltmr + 1'b1;
            end
         end
         default: st_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         code      <= DEFAULT_CODE;
         shadow    <= '0;
         digit_cnt <= 2'd0;
         fail_cnt  <= 3'd0;
         mis       <= 1'b0;
         otmr      <= '0;
         ltmr      <= '0;
         unlock    <= 1'b0;
         alarm     <= 1'b0;
         err       <= 1'b0;
         code_set  <= 1'b0;
      end else begin
         state     <= st_nx;
         code      <= code_nx;
         shadow    <= shadow_nx;
         digit_cnt <= cnt_nx;
         fail_cnt  <= fail_nx;
         mis       <= mis_nx;
         otmr      <= otmr_nx;
         ltmr      <= ltmr_nx;
         unlock    <= (st_nx == S_OPEN);
         alarm     <= (st_nx == S_LOCK);
         err       <= err_nx;
         code_set  <= set_nx;
      end
   end
endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm: directed scenarios plus random keypad
// traffic, checked against a queue-based behavioural model of the lock.

module tb_code_lock_fsm;
   localparam int OPEN_CYCLES = 8;
   localparam int MAX_FAILS   = 3;
   localparam int LOCK_CYCLES = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_in = 4'h0;
   logic       clear = 1'b0;
   logic       set_req = 1'b0;
   logic       unlock, alarm, err, code_set;
   logic [1:0] digit_cnt;
   logic [2:0] fail_cnt;

   code_lock_fsm #(
      .DEFAULT_CODE(16'h1234), .OPEN_CYCLES(OPEN_CYCLES),
      .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
      .clear(clear), .set_req(set_req), .unlock(unlock), .alarm(alarm),
      .err(err), .code_set(code_set), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       unlock;
      logic       alarm;
      logic       err;
      logic       code_set;
      logic [1:0] dc;
      logic [2:0] fc;
   } obs_t;

   obs_t expq[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Behavioural model: modes, typed-digit queues and remaining-cycle counts
   localparam int M_READY = 0, M_OPEN = 1, M_SET = 2, M_LOCK = 3;
   int          mode;
   logic [3:0]  ent[$];
   logic [3:0]  nc[$];
   logic [15:0] mcode;
   int          fails, open_left, lock_left;

   task automatic model_reset();
      mode = M_READY; ent.delete(); nc.delete();
      mcode = 16'h1234; fails = 0; open_left = 0; lock_left = 0;
   endtask

   task automatic cyc(input logic k, input logic [3:0] d, input logic c, input logic s);
      logic errp, csp;
      logic [15:0] typed;
      obs_t e;
      @(negedge clk);
      key_valid = k; key_in = d; clear = c; set_req = s;
      errp = 1'b0; csp = 1'b0;
      case (mode)
         M_READY: begin
            if (c) ent.delete();
            else if (k) begin
               ent.push_back(d);
               if (ent.size() == 4) begin
                  typed = {ent[0], ent[1], ent[2], ent[3]};
                  ent.delete();
                  if (typed == mcode) begin
                     mode = M_OPEN; open_left = OPEN_CYCLES; fails = 0;
                  end else begin
                     errp = 1'b1; fails++;
                     if (fails == MAX_FAILS) begin
                        mode = M_LOCK; lock_left = LOCK_CYCLES;
                     end
                  end
               end
            end
         end
         M_OPEN: begin
            if (c) mode = M_READY;
            else if (s) begin mode = M_SET; nc.delete(); end
            else begin
               open_left--;
               if (open_left == 0) mode = M_READY;
            end
         end
         M_SET: begin
            if (c) begin mode = M_READY; nc.delete(); end
            else if (k) begin
               nc.push_back(d);
               if (nc.size() == 4) begin
                  mcode = {nc[0], nc[1], nc[2], nc[3]};
                  nc.delete(); csp = 1'b1; mode = M_READY;
               end
            end
         end
         default: begin
            lock_left--;
            if (lock_left == 0) begin mode = M_READY; fails = 0; end
         end
      endcase
      e.unlock   = (mode == M_OPEN);
      e.alarm    = (mode == M_LOCK);
      e.err      = errp;
      e.code_set = csp;
      e.dc       = (mode == M_READY) ? 2'(ent.size()) : (mode == M_SET) ? 2'(nc.size()) : 2'd0;
      e.fc       = 3'(fails);
      expq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic enter(input logic [15:0] c);
      for (int i = 0; i < 4; i++) cyc(1'b1, c[4*(3-i) +: 4], 1'b0, 1'b0);
   endtask

   // Async reset between edges; outputs must drop with no clock edge
   task automatic async_rst(input string tag);
      obs_t a;
      @(posedge clk); #3;
      rst_n = 1'b0; key_valid = 1'b0; clear = 1'b0; set_req = 1'b0;
      #1;
      a = {unlock, alarm, err, code_set, digit_cnt, fail_cnt};
      vectors++;
      if (a !== '0) begin
         miscompares++;
         $display("FAIL reset_%s outputs got %b need 0", tag, a);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin : monitor
      obs_t e, a;
      forever begin
         @(posedge clk); #1;
         if (rst_n && expq.size() > 0) begin
            e = expq.pop_front();
            a = {unlock, alarm, err, code_set, digit_cnt, fail_cnt};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL outputs t=%0t got unl=%b alm=%b err=%b cs=%b dc=%0d fc=%0d need unl=%b alm=%b err=%b cs=%b dc=%0d fc=%0d",
                        $time, a.unlock, a.alarm, a.err, a.code_set, a.dc, a.fc,
                        e.unlock, e.alarm, e.err, e.code_set, e.dc, e.fc);
            end
         end
      end
   end

   initial begin : stim
      obs_t a;
      logic [3:0] d;
      int pos;
      model_reset();
      #2;
      a = {unlock, alarm, err, code_set, digit_cnt, fail_cnt};
      vectors++;
      if (a !== '0) begin
         miscompares++;
         $display("FAIL reset_init outputs got %b need 0", a);
      end
      @(negedge clk); rst_n = 1'b1;

      // correct entry, then timeout back to idle
      enter(16'h1234); idle(10);
      // two wrong entries, then correct clears fail count
      enter(16'h1235); enter(16'h1235); enter(16'h1234); idle(10);
      // lockout, ignored entry during lockout, unlock afterwards
      enter(16'h1235); enter(16'h9999); enter(16'h0000);
      enter(16'h1234); cyc(1'b1, 4'h1, 1'b1, 1'b1); idle(13);
      enter(16'h1234); idle(9);
      // clear mid-entry, clear in open, clear with key_valid
      enter(16'h1235);
      cyc(1'b1, 4'h1, 1'b0, 1'b0); cyc(1'b1, 4'h2, 1'b0, 1'b0);
      cyc(1'b0, 4'h0, 1'b1, 1'b0); enter(16'h1234);
      idle(2); cyc(1'b0, 4'h0, 1'b1, 1'b0); idle(1);
      cyc(1'b1, 4'h1, 1'b1, 1'b0); idle(1);
      enter(16'h1234); idle(9);
      // code change, old code rejected, new code accepted, aborted set
      enter(16'h1234); cyc(1'b0, 4'h0, 1'b0, 1'b1); enter(16'hABCD);
      enter(16'h1234); enter(16'hABCD);
      cyc(1'b0, 4'h0, 1'b0, 1'b1);
      cyc(1'b1, 4'h5, 1'b0, 1'b0); cyc(1'b1, 4'h6, 1'b0, 1'b0);
      cyc(1'b0, 4'h0, 1'b1, 1'b0);
      enter(16'hABCD); idle(9);

      // async resets mid-entry, mid-open, mid-lockout after a code change
      cyc(1'b1, 4'hA, 1'b0, 1'b0); cyc(1'b1, 4'hB, 1'b0, 1'b0);
      async_rst("entry");
      enter(16'h1234); cyc(1'b0, 4'h0, 1'b0, 1'b1); enter(16'h7777);
      enter(16'h7777); idle(2);
      async_rst("open");
      enter(16'h1234); idle(9);
      enter(16'h1234); cyc(1'b0, 4'h0, 1'b0, 1'b1); enter(16'h4321);
      enter(16'h1111); enter(16'h2222); enter(16'h3333); idle(4);
      async_rst("lockout");
      enter(16'h1234); idle(9);

      // random traffic, biased toward the current code's digits
      for (int n = 0; n < 3000; n++) begin
         pos = (mode == M_READY) ? ent.size() : 0;
         d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : mcode[4*(3-pos) +: 4];
         cyc(($urandom_range(0, 99) < 55), d,
             ($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0));
      end
      idle(1);
      @(negedge clk); @(negedge clk);
      vectors++;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending need 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
